// File: rtl/ariane_pkg.sv
// Core-wide types and constants used by the execute stage.
package ariane_pkg;

  typedef enum logic [1:0] {
    SfenceIdle,
    SfenceWaitCommit,
    SfenceDrain,
    SfenceFlush
  } sfence_state_e;

  localparam int unsigned SFENCE_DRAIN_CNT_W = 16;

endpackage

// File: rtl/riscv_pkg.sv
// Minimal RISC-V architectural constants shared across the core.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

// File: rtl/sfence_vma_ctrl.sv
// SFENCE.VMA sequencer: captures operands at issue, waits for commit, drains
// outstanding stores, then emits a single-cycle TLB flush strobe.
module sfence_vma_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned VLEN       = riscv::VLEN
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  input  logic [VLEN-1:0]               rs1_i,
  input  logic [ASID_WIDTH-1:0]         rs2_i,
  input  logic                          rs1_is_x0_i,
  input  logic                          rs2_is_x0_i,
  input  logic                          commit_i,
  input  logic                          no_st_pending_i,
  input  logic                          wbuffer_empty_i,
  output logic                          ready_o,
  output logic                          busy_o,
  output logic                          flush_tlb_o,
  output logic [VLEN-1:0]               vaddr_o,
  output logic [ASID_WIDTH-1:0]         asid_o,
  output logic                          flush_all_vaddr_o,
  output logic                          flush_all_asid_o,
  output logic [SFENCE_DRAIN_CNT_W-1:0] drain_cycles_o
);

  sfence_state_e                 state_d, state_q;
  logic [VLEN-1:0]               vaddr_d, vaddr_q;
  logic [ASID_WIDTH-1:0]         asid_d, asid_q;
  logic                          all_va_d, all_va_q;
  logic                          all_asid_d, all_asid_q;
  logic [SFENCE_DRAIN_CNT_W-1:0] cnt_d, cnt_q;
  logic                          drained;

  assign drained = no_st_pending_i & wbuffer_empty_i;

  always_comb begin
    state_d    = state_q;
    vaddr_d    = vaddr_q;
    asid_d     = asid_q;
    all_va_d   = all_va_q;
    all_asid_d = all_asid_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      SfenceIdle: begin
        if (issue_valid_i && !flush_i) begin
          vaddr_d    = rs1_i;
          asid_d     = rs2_i;
          all_va_d   = rs1_is_x0_i;
          all_asid_d = rs2_is_x0_i;
          state_d    = SfenceWaitCommit;
        end
      end
      SfenceWaitCommit: begin
        // A squash outranks a same-cycle commit.
        if (flush_i) begin
          state_d = SfenceIdle;
        end else if (commit_i) begin
          cnt_d   = '0;
          state_d = SfenceDrain;
        end
      end
      SfenceDrain: begin
        // Already committed, so flush_i is deliberately not looked at here.
        if (drained) begin
          state_d = SfenceFlush;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + SFENCE_DRAIN_CNT_W'(1);
        end
      end
      SfenceFlush: state_d = SfenceIdle;
      default:     state_d = SfenceIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SfenceIdle;
      vaddr_q    <= '0;
      asid_q     <= '0;
      all_va_q   <= 1'b0;
      all_asid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      vaddr_q    <= vaddr_d;
      asid_q     <= asid_d;
      all_va_q   <= all_va_d;
      all_asid_q <= all_asid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o           = (state_q == SfenceIdle);
  assign busy_o            = (state_q != SfenceIdle);
  assign flush_tlb_o       = (state_q == SfenceFlush);
  assign vaddr_o           = vaddr_q;
  assign asid_o            = asid_q;
  assign flush_all_vaddr_o = all_va_q;
  assign flush_all_asid_o  = all_asid_q;
  assign drain_cycles_o    = cnt_q;

endmodule

// File: tb/tb_sfence_vma_ctrl.sv
// Self-checking bench for sfence_vma_ctrl: vector table, directed corner
// sequences and randomized traffic against a flag-based reference model.
module tb_sfence_vma_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned VW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, issue, commit, no_st, wbuf, x1, x2;
  logic [VW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          ready, busy, tlb, fav, faa;
  logic [VW-1:0] vaddr;
  logic [AW-1:0] asid;
  logic [15:0]   cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sfence_vma_ctrl #(.ASID_WIDTH(AW), .VLEN(VW)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .issue_valid_i     (issue),
    .rs1_i             (rs1),
    .rs2_i             (rs2),
    .rs1_is_x0_i       (x1),
    .rs2_is_x0_i       (x2),
    .commit_i          (commit),
    .no_st_pending_i   (no_st),
    .wbuffer_empty_i   (wbuf),
    .ready_o           (ready),
    .busy_o            (busy),
    .flush_tlb_o       (tlb),
    .vaddr_o           (vaddr),
    .asid_o            (asid),
    .flush_all_vaddr_o (fav),
    .flush_all_asid_o  (faa),
    .drain_cycles_o    (cnt)
  );

  // Reference model: a fence is either captured-but-uncommitted, committed
  // and waiting for the stores to drain, or about to strobe.
  logic          m_pending, m_committed, m_strobe;
  logic [VW-1:0] m_vaddr;
  logic [AW-1:0] m_asid;
  logic          m_fav, m_faa;
  int            m_cnt;

  function automatic void model_reset();
    m_pending = 0; m_committed = 0; m_strobe = 0;
    m_vaddr = '0; m_asid = '0; m_fav = 0; m_faa = 0; m_cnt = 0;
  endfunction

  function automatic void model_update();
    if (m_strobe) begin
      m_strobe = 0;
    end else if (m_committed) begin
      if (no_st && wbuf) begin
        m_committed = 0;
        m_strobe    = 1;
      end else begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
    end else if (m_pending) begin
      if (flush) m_pending = 0;
      else if (commit) begin
        m_pending = 0; m_committed = 1; m_cnt = 0;
      end
    end else if (issue && !flush) begin
      m_vaddr = rs1; m_asid = rs2; m_fav = x1; m_faa = x2; m_pending = 1;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic idle;
    idle = !(m_pending || m_committed || m_strobe);
    chk("rnd_ready", 64'(ready), 64'(idle));
    chk("rnd_busy",  64'(busy),  64'(!idle));
    chk("rnd_tlb",   64'(tlb),   64'(m_strobe));
    chk("rnd_vaddr", vaddr,      m_vaddr);
    chk("rnd_asid",  64'(asid),  64'(m_asid));
    chk("rnd_fav",   64'(fav),   64'(m_fav));
    chk("rnd_faa",   64'(faa),   64'(m_faa));
    chk("rnd_cnt",   64'(cnt),   64'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic idle_inputs();
    issue = 0; flush = 0; commit = 0; no_st = 1; wbuf = 1; x1 = 0; x2 = 0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    step();
    step();
    rst_n = 1;
  endtask

  typedef struct {
    logic iss, fl, cm, dr, rx1, rx2;
    logic [63:0] r1;
    logic [3:0]  r2;
    logic e_rdy, e_busy, e_tlb;
    logic [63:0] e_va;
    logic [3:0]  e_asid;
    logic e_fav, e_faa;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Outputs are the state after the clock edge that samples the row's inputs.
    vecs[0]  = '{1,0,0,1,0,0, 64'h8000_1000, 4'd1, 0,1,0, 64'h8000_1000, 4'd1, 0,0, 16'd0};
    vecs[1]  = '{0,0,1,1,0,0, 64'h0,         4'd0, 0,1,0, 64'h8000_1000, 4'd1, 0,0, 16'd0};
    vecs[2]  = '{0,0,0,1,0,0, 64'h0,         4'd0, 0,1,1, 64'h8000_1000, 4'd1, 0,0, 16'd0};
    vecs[3]  = '{0,0,0,1,0,0, 64'h0,         4'd0, 1,0,0, 64'h8000_1000, 4'd1, 0,0, 16'd0};
    vecs[4]  = '{1,0,0,1,0,1, 64'h2000,      4'd0, 0,1,0, 64'h2000,      4'd0, 0,1, 16'd0};
    vecs[5]  = '{0,1,1,1,0,0, 64'h0,         4'd0, 1,0,0, 64'h2000,      4'd0, 0,1, 16'd0};
    vecs[6]  = '{0,0,0,1,0,0, 64'h0,         4'd0, 1,0,0, 64'h2000,      4'd0, 0,1, 16'd0};
    vecs[7]  = '{1,0,0,1,1,0, 64'h3000,      4'd5, 0,1,0, 64'h3000,      4'd5, 1,0, 16'd0};
    vecs[8]  = '{1,0,0,1,0,0, 64'h1234,      4'd7, 0,1,0, 64'h3000,      4'd5, 1,0, 16'd0};
    vecs[9]  = '{1,0,1,1,0,0, 64'h1234,      4'd7, 0,1,0, 64'h3000,      4'd5, 1,0, 16'd0};
    vecs[10] = '{1,0,0,1,0,0, 64'h1234,      4'd7, 0,1,1, 64'h3000,      4'd5, 1,0, 16'd0};
    vecs[11] = '{1,0,0,1,0,0, 64'h1234,      4'd7, 1,0,0, 64'h3000,      4'd5, 1,0, 16'd0};
    vecs[12] = '{0,0,1,1,0,0, 64'h0,         4'd0, 1,0,0, 64'h3000,      4'd5, 1,0, 16'd0};
    vecs[13] = '{1,1,0,1,0,0, 64'h1234,      4'd7, 1,0,0, 64'h3000,      4'd5, 1,0, 16'd0};

    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_tlb",   64'(tlb),   64'd0);
    chk("rst_vaddr", vaddr,      64'd0);
    chk("rst_cnt",   64'(cnt),   64'd0);
    step();
    step();
    rst_n = 1;

    // Table: basic flow, squash, back-to-back issue, ignored commit/issue.
    for (int i = 0; i < 14; i++) begin
      issue = vecs[i].iss; flush = vecs[i].fl; commit = vecs[i].cm;
      no_st = vecs[i].dr; wbuf = vecs[i].dr; x1 = vecs[i].rx1; x2 = vecs[i].rx2;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      step();
      chk($sformatf("v%0d_ready", i), 64'(ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_busy", i),  64'(busy),  64'(vecs[i].e_busy));
      chk($sformatf("v%0d_tlb", i),   64'(tlb),   64'(vecs[i].e_tlb));
      chk($sformatf("v%0d_vaddr", i), vaddr,      vecs[i].e_va);
      chk($sformatf("v%0d_asid", i),  64'(asid),  64'(vecs[i].e_asid));
      chk($sformatf("v%0d_fav", i),   64'(fav),   64'(vecs[i].e_fav));
      chk($sformatf("v%0d_faa", i),   64'(faa),   64'(vecs[i].e_faa));
      chk($sformatf("v%0d_cnt", i),   64'(cnt),   64'(vecs[i].e_cnt));
    end

    // Slow drain with a flush pulse that must be ignored.
    idle_inputs();
    issue = 1; rs1 = 64'h5000; rs2 = 4'd2;
    step();
    idle_inputs();
    commit = 1;
    step();
    chk("slow_cnt_clear", 64'(cnt), 64'd0);
    idle_inputs();
    no_st = 0;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      step();
      chk("slow_no_tlb", 64'(tlb), 64'd0);
    end
    chk("slow_busy", 64'(busy), 64'd1);
    chk("slow_cnt5", 64'(cnt), 64'd5);
    idle_inputs();
    step();
    chk("slow_tlb", 64'(tlb), 64'd1);
    chk("slow_cnt_hold", 64'(cnt), 64'd5);
    step();
    chk("slow_tlb_off", 64'(tlb), 64'd0);
    chk("slow_ready", 64'(ready), 64'd1);
    chk("slow_vaddr", vaddr, 64'h5000);

    // Asynchronous reset while draining.
    issue = 1; rs1 = 64'h7000; rs2 = 4'd3; x2 = 1;
    step();
    idle_inputs();
    commit = 1;
    step();
    idle_inputs();
    wbuf = 0;
    step(); step(); step();
    chk("mid_cnt3", 64'(cnt), 64'd3);
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_busy",  64'(busy),  64'd0);
    chk("mid_rst_tlb",   64'(tlb),   64'd0);
    chk("mid_rst_vaddr", vaddr,      64'd0);
    chk("mid_rst_asid",  64'(asid),  64'd0);
    chk("mid_rst_faa",   64'(faa),   64'd0);
    chk("mid_rst_cnt",   64'(cnt),   64'd0);
    step();
    rst_n = 1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_post_tlb", 64'(tlb), 64'd0);
      chk("mid_post_ready", 64'(ready), 64'd1);
    end

    // Counter saturation.
    issue = 1; rs1 = 64'h9000;
    step();
    idle_inputs();
    commit = 1;
    step();
    idle_inputs();
    no_st = 0; wbuf = 0;
    for (int i = 0; i < 70000; i++) step();
    chk("sat_cnt", 64'(cnt), 64'hFFFF);
    chk("sat_busy", 64'(busy), 64'd1);
    idle_inputs();
    step();
    chk("sat_tlb", 64'(tlb), 64'd1);
    chk("sat_cnt_hold", 64'(cnt), 64'hFFFF);
    step();

    // Randomized traffic against the reference model.
    idle_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      issue  = ($urandom_range(1) == 1);
      flush  = ($urandom_range(7) == 0);
      commit = ($urandom_range(2) == 0);
      no_st  = ($urandom_range(3) != 0);
      wbuf   = ($urandom_range(3) != 0);
      x1     = ($urandom_range(3) == 0);
      x2     = ($urandom_range(3) == 0);
      rs1    = {$urandom, $urandom};
      rs2    = AW'($urandom);
      step();
      chk_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfence_vma_ctrl.md
SFENCE_VMA_CTRL -- requirements
Module: sfence_vma_ctrl

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 1, the width of the captured ASID.
REQ-002 SHALL have parameter VLEN, default riscv::VLEN, the width of the captured virtual address.
REQ-003 SHALL have port clk_i  in  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  pipeline flush; squashes uncommitted fences.
REQ-006 SHALL have port issue_valid_i  in  1  an SFENCE.VMA is in EX (csr_valid and operator SFENCE_VMA).
REQ-007 SHALL have ports rs1_i  in  VLEN  vaddr operand, and rs2_i  in  ASID_WIDTH  asid operand.
REQ-008 SHALL have ports rs1_is_x0_i and rs2_is_x0_i  in  1 each  the operand register index is x0.
REQ-009 SHALL have port commit_i  in  1  the fence retires this cycle.
REQ-010 SHALL have ports no_st_pending_i and wbuffer_empty_i  in  1 each  the LSU and D$ write paths are drained.
REQ-011 SHALL have port ready_o  out  1  able to accept issue_valid_i.
REQ-012 SHALL have port busy_o  out  1  a fence is in flight; the issue stage stalls on it.
REQ-013 SHALL have port flush_tlb_o  out  1  one-cycle TLB flush strobe.
REQ-014 SHALL have ports vaddr_o  out  VLEN  and asid_o  out  ASID_WIDTH  hold the captured operands.
REQ-015 SHALL have ports flush_all_vaddr_o and flush_all_asid_o  out  1 each  hold the captured x0 flags.
REQ-016 SHALL have port drain_cycles_o  out  16  saturating count of cycles spent in the last drain.

Function
REQ-017 SHALL implement an FSM with states IDLE, WAIT_COMMIT, DRAIN and FLUSH.
REQ-018 In IDLE, issue_valid_i=1 with flush_i=0 SHALL capture rs1_i, rs2_i and both x0 flags, and SHALL move to WAIT_COMMIT next cycle.
REQ-019 ready_o SHALL be 1 only in IDLE; issue_valid_i outside IDLE SHALL be ignored and SHALL NOT change the captured values.
REQ-020 In WAIT_COMMIT, flush_i=1 SHALL return to IDLE without a strobe; if flush_i and commit_i are both 1, flush_i SHALL win.
REQ-021 In WAIT_COMMIT, commit_i=1 with flush_i=0 SHALL move to DRAIN and SHALL clear drain_cycles_o to 0.
REQ-022 In DRAIN, when no_st_pending_i and wbuffer_empty_i are both 1, the FSM SHALL move to FLUSH next cycle; otherwise drain_cycles_o SHALL increment each cycle and saturate at 0xFFFF.
REQ-023 DRAIN and FLUSH SHALL ignore flush_i, because the fence has already committed.
REQ-024 FLUSH SHALL last exactly one cycle, SHALL assert flush_tlb_o for that cycle only, and SHALL return to IDLE.
REQ-025 flush_tlb_o SHALL be a registered output (state==FLUSH).
REQ-026 Minimum latency SHALL be commit_i at cycle N, drained inputs at N+1, flush_tlb_o at N+2.
REQ-027 busy_o SHALL be 1 in WAIT_COMMIT, DRAIN and FLUSH.
REQ-028 vaddr_o, asid_o and the flush_all flags SHALL hold their captured values until the next capture.
REQ-029 commit_i in IDLE or DRAIN SHALL be ignored.

Reset
REQ-030 On rst_ni=0 the FSM SHALL enter IDLE asynchronously, including mid-operation, with any in-flight fence dropped.
REQ-031 On reset, ready_o=1, busy_o=0 and flush_tlb_o=0.
REQ-032 On reset, vaddr_o, asid_o, both flush_all flags and drain_cycles_o SHALL be 0.

Structure
REQ-033 The state enum sfence_state_e SHALL be declared in ariane_pkg.
REQ-034 The constant SFENCE_DRAIN_CNT_W=16 SHALL be declared in ariane_pkg.
REQ-035 The block SHALL be flat RTL with no sub-module; the saturating counter SHALL be inline.
REQ-036 The block SHALL be instantiated in ex_stage, where it replaces the ad-hoc sfence operand registers.

Verification
REQ-037 Basic flow: issue with rs1=0x8000_1000, rs2=1, commit next cycle, drain inputs held 1 -> flush_tlb_o high for one cycle 2 cycles after commit, vaddr_o=0x8000_1000, asid_o=1, drain_cycles_o=0.
REQ-038 Squash: issue, then flush_i and commit_i together in WAIT_COMMIT -> IDLE, flush_tlb_o never asserted, ready_o=1 next cycle.
REQ-039 Slow drain: commit, then no_st_pending_i=0 for 5 cycles -> drain_cycles_o=5 and the strobe follows the first drained cycle by 1; flush_i pulsed during DRAIN has no effect.
REQ-040 Back-to-back issue: second issue_valid_i with rs1=0x1234 while busy -> ignored, vaddr_o unchanged, ready_o=0 until return to IDLE.
REQ-041 Reset mid-DRAIN: assert rst_ni=0 -> IDLE immediately, all outputs at reset values, no strobe after reset release.
REQ-042 Saturation: hold the drain inputs at 0 for 70000 cycles -> drain_cycles_o=0xFFFF with no wrap.
